// File: rtl/aimc_ui_ingress_if.sv
// Host-to-scheduler ingress bundle: upstream push port, downstream scheduler port,
// calibration gate, fill-level flow control and protocol error reporting.
interface aimc_ui_ingress_if #(
  parameter int PKT_W = 32,
  parameter int DEPTH = 16
);
  logic                     cal_done;
  logic [PKT_W-1:0]         up_pkt;
  logic                     up_pkt_valid;
  logic                     up_rdy;
  logic [PKT_W-1:0]         ui_pkt;
  logic                     ui_pkt_valid;
  logic                     sched_rdy;
  logic [$clog2(DEPTH):0]   fill_cnt;
  logic                     almost_full;
  logic                     proto_err;
  logic                     err_clr;

  modport master (
    output cal_done, up_pkt, up_pkt_valid, sched_rdy, err_clr,
    input  up_rdy, ui_pkt, ui_pkt_valid, fill_cnt, almost_full, proto_err
  );

  modport slave (
    input  cal_done, up_pkt, up_pkt_valid, sched_rdy, err_clr,
    output up_rdy, ui_pkt, ui_pkt_valid, fill_cnt, almost_full, proto_err
  );
endinterface

// File: rtl/aimc_ui_ingress.sv
// AiM controller UI ingress queue: DEPTH-1 entry circular RAM plus a first-word
// fall-through output register, gated by calibration, with upstream protocol checking.
module aimc_ui_ingress #(
  parameter int PKT_W    = 32,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12
) (
  input logic              clk,
  input logic              rst,
  aimc_ui_ingress_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH - 1);
  localparam int RAM_N = DEPTH - 1;

  logic [PKT_W-1:0] ram [RAM_N];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             up_rdy_q, up_rdy_d;
  logic             out_full_q, out_full_d;
  logic             ui_pkt_valid_q, ui_pkt_valid_d;
  logic [PKT_W-1:0] ui_pkt_q, ui_pkt_d;
  logic             almost_full_q, almost_full_d;
  logic             proto_err_q, proto_err_d;
  logic             arm_q, arm_d;
  logic [PKT_W-1:0] prev_pkt_q, prev_pkt_d;

  logic push, pop, ram_empty, load, ram_wr, viol;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RAM_N - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    push      = bus.up_pkt_valid & up_rdy_q;
    pop       = ui_pkt_valid_q & bus.sched_rdy;
    // RAM occupancy is the total count minus whatever sits in the output register
    ram_empty = (fill_cnt_q == CNT_W'(out_full_q));
    load      = (!out_full_q || pop) && (!ram_empty || push);
    ram_wr    = push && !(load && ram_empty);

    wptr_d = ram_wr ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = (load && !ram_empty) ? ptr_inc(rptr_q) : rptr_q;

    out_full_d     = out_full_q;
    ui_pkt_valid_d = ui_pkt_valid_q;
    ui_pkt_d       = ui_pkt_q;
    if (load) begin
      out_full_d     = 1'b1;
      ui_pkt_valid_d = bus.cal_done;
      ui_pkt_d       = ram_empty ? bus.up_pkt : ram[rptr_q];
    end else if (pop) begin
      out_full_d     = 1'b0;
      ui_pkt_valid_d = 1'b0;
    end else if (out_full_q && !ui_pkt_valid_q && bus.cal_done) begin
      // Packet loaded while calibration was pending; present it now
      ui_pkt_valid_d = 1'b1;
    end

    fill_cnt_d    = fill_cnt_q + CNT_W'(push) - CNT_W'(pop);
    up_rdy_d      = (fill_cnt_d < CNT_W'(DEPTH));
    almost_full_d = (fill_cnt_d >= CNT_W'(AFULL_TH));

    arm_d       = bus.up_pkt_valid & ~up_rdy_q;
    prev_pkt_d  = bus.up_pkt;
    viol        = arm_q && (!bus.up_pkt_valid || (bus.up_pkt != prev_pkt_q));
    proto_err_d = viol ? 1'b1 : (bus.err_clr ? 1'b0 : proto_err_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      fill_cnt_q     <= '0;
      up_rdy_q       <= 1'b0;
      out_full_q     <= 1'b0;
      ui_pkt_valid_q <= 1'b0;
      ui_pkt_q       <= '0;
      almost_full_q  <= 1'b0;
      proto_err_q    <= 1'b0;
      arm_q          <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      fill_cnt_q     <= fill_cnt_d;
      up_rdy_q       <= up_rdy_d;
      out_full_q     <= out_full_d;
      ui_pkt_valid_q <= ui_pkt_valid_d;
      ui_pkt_q       <= ui_pkt_d;
      almost_full_q  <= almost_full_d;
      proto_err_q    <= proto_err_d;
      arm_q          <= arm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) ram[wptr_q] <= bus.up_pkt;
    prev_pkt_q <= prev_pkt_d;
  end

  assign bus.up_rdy       = up_rdy_q;
  assign bus.ui_pkt       = ui_pkt_q;
  assign bus.ui_pkt_valid = ui_pkt_valid_q;
  assign bus.fill_cnt     = fill_cnt_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.proto_err    = proto_err_q;

endmodule

// File: tb/tb_aimc_ui_ingress.sv
// Scoreboard bench for aimc_ui_ingress: directed scenarios plus a random stream,
// every accepted packet queued and compared against the scheduler-side output.
module tb_aimc_ui_ingress;
  localparam int PKT_W    = 32;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 12;

  logic clk = 1'b0;
  logic rst;

  aimc_ui_ingress_if #(.PKT_W(PKT_W), .DEPTH(DEPTH)) bus ();

  aimc_ui_ingress #(.PKT_W(PKT_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PKT_W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.sched_rdy    = 1'b1;
    bus.up_pkt_valid = 1'b0;
    for (int i = 0; i < 100 && (bus.fill_cnt != 0 || bus.ui_pkt_valid); i++) tick();
    check("drain_fill", 64'(bus.fill_cnt), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_up_rdy"},   64'(bus.up_rdy), 64'd0);
    check({tag, "_valid"},    64'(bus.ui_pkt_valid), 64'd0);
    check({tag, "_pkt"},      64'(bus.ui_pkt), 64'd0);
    check({tag, "_fill"},     64'(bus.fill_cnt), 64'd0);
    check({tag, "_afull"},    64'(bus.almost_full), 64'd0);
    check({tag, "_proto"},    64'(bus.proto_err), 64'd0);
  endtask

  // Scoreboard: inputs change 1ns after the rising edge, so the falling edge sees
  // exactly the values the next rising edge will act on.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      check("fill_vs_sb", 64'(bus.fill_cnt), 64'(exp_q.size()));
      check("afull_vs_sb", 64'(bus.almost_full), 64'(exp_q.size() >= AFULL_TH));
      if (bus.ui_pkt_valid && bus.sched_rdy) begin
        if (exp_q.size() == 0) check("pop_with_empty_sb", 64'(bus.ui_pkt_valid), 64'd0);
        else check("ui_pkt_order", 64'(bus.ui_pkt), 64'(exp_q.pop_front()));
      end
      if (bus.up_pkt_valid && bus.up_rdy) exp_q.push_back(bus.up_pkt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cal_done     = 1'b1;
    bus.up_pkt       = '0;
    bus.up_pkt_valid = 1'b0;
    bus.sched_rdy    = 1'b0;
    bus.err_clr      = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_reset_vals("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    check("up_rdy_before_edge", 64'(bus.up_rdy), 64'd0);
    tick();
    check("up_rdy_after_release", 64'(bus.up_rdy), 64'd1);
    mon_en = 1'b1;

    // Single packet, one-cycle latency
    bus.sched_rdy    = 1'b1;
    bus.up_pkt       = 32'hA5;
    bus.up_pkt_valid = 1'b1;
    tick();
    bus.up_pkt_valid = 1'b0;
    check("single_valid", 64'(bus.ui_pkt_valid), 64'd1);
    check("single_pkt", 64'(bus.ui_pkt), 64'hA5);
    tick();
    check("single_fill_zero", 64'(bus.fill_cnt), 64'd0);
    check("single_valid_drop", 64'(bus.ui_pkt_valid), 64'd0);

    // Fill to full with the scheduler stalled
    bus.sched_rdy = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      bus.up_pkt       = 32'(i);
      bus.up_pkt_valid = 1'b1;
      tick();
      check("fill_cnt_ramp", 64'(bus.fill_cnt), 64'(i));
      check("afull_ramp", 64'(bus.almost_full), 64'(i >= AFULL_TH));
    end
    bus.up_pkt_valid = 1'b0;
    check("full_up_rdy", 64'(bus.up_rdy), 64'd0);
    bus.sched_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("stream_valid", 64'(bus.ui_pkt_valid), 64'd1);
      check("stream_pkt", 64'(bus.ui_pkt), 64'(i));
      tick();
    end
    check("stream_empty_valid", 64'(bus.ui_pkt_valid), 64'd0);
    check("stream_empty_fill", 64'(bus.fill_cnt), 64'd0);

    // Full queue, single pop with host valid held
    bus.sched_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.up_pkt       = 32'h21 + 32'(i);
      bus.up_pkt_valid = 1'b1;
      tick();
    end
    bus.up_pkt = 32'h31;
    tick();
    tick();
    check("held_up_rdy", 64'(bus.up_rdy), 64'd0);
    check("held_fill", 64'(bus.fill_cnt), 64'd16);
    bus.sched_rdy = 1'b1;
    tick();
    bus.sched_rdy = 1'b0;
    check("reopen_up_rdy", 64'(bus.up_rdy), 64'd1);
    check("reopen_fill", 64'(bus.fill_cnt), 64'd15);
    tick();
    bus.up_pkt_valid = 1'b0;
    check("refill_fill", 64'(bus.fill_cnt), 64'd16);
    check("refill_up_rdy", 64'(bus.up_rdy), 64'd0);
    check("held_no_proto", 64'(bus.proto_err), 64'd0);
    drain();

    // Calibration gating
    bus.cal_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.up_pkt       = 32'h41 + 32'(i);
      bus.up_pkt_valid = 1'b1;
      tick();
      check("cal_gate_valid", 64'(bus.ui_pkt_valid), 64'd0);
    end
    bus.up_pkt_valid = 1'b0;
    tick();
    tick();
    check("cal_gate_valid_idle", 64'(bus.ui_pkt_valid), 64'd0);
    check("cal_gate_fill", 64'(bus.fill_cnt), 64'd3);
    bus.cal_done = 1'b1;
    tick();
    check("cal_release_valid", 64'(bus.ui_pkt_valid), 64'd1);
    check("cal_release_pkt", 64'(bus.ui_pkt), 64'h41);
    drain();

    // Upstream protocol violation
    bus.sched_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.up_pkt       = 32'h51 + 32'(i);
      bus.up_pkt_valid = 1'b1;
      tick();
    end
    bus.up_pkt = 32'h70;
    tick();
    check("proto_stable_hold", 64'(bus.proto_err), 64'd0);
    bus.up_pkt = 32'h71;
    tick();
    check("proto_set", 64'(bus.proto_err), 64'd1);
    bus.up_pkt_valid = 1'b0;
    tick();
    tick();
    check("proto_sticky", 64'(bus.proto_err), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("proto_cleared", 64'(bus.proto_err), 64'd0);

    // Reset with packets queued
    bus.sched_rdy = 1'b1;
    repeat (11) tick();
    bus.sched_rdy = 1'b0;
    check("pre_reset_fill", 64'(bus.fill_cnt), 64'd5);
    check("pre_reset_valid", 64'(bus.ui_pkt_valid), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("midreset");
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus.sched_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_stale_valid", 64'(bus.ui_pkt_valid), 64'd0);
    end
    check("post_reset_fill", 64'(bus.fill_cnt), 64'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bus.up_pkt_valid = 1'($urandom_range(0, 1));
      bus.up_pkt       = $urandom;
      bus.sched_rdy    = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("sb_empty_at_end", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
